// File: rtl/pixel_sink_if.sv
// Pixel-write bus from the drawing blocks plus the framebuffer write port,
// bundled so the sink sees both sides of its datapath through one port.
interface pixel_sink_if #(
    parameter int ADDR_W = 15
);
    logic [10:0]       x_in;
    logic [10:0]       y_in;
    logic [2:0]        colour_in;
    logic              writeEn;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_data;
    logic              mem_we;
    logic              mem_ready;

    // master: drawers + framebuffer side; slave: the pixel sink itself
    modport master (
        output x_in, y_in, colour_in, writeEn, mem_ready,
        input  mem_addr, mem_data, mem_we
    );
    modport slave (
        input  x_in, y_in, colour_in, writeEn, mem_ready,
        output mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/pixel_sink.sv
// Clips drawer pixel writes, linearises (x,y) into a framebuffer address and
// buffers them in a small FIFO drained under a valid/ready handshake.
module pixel_sink #(
    parameter  int SCREEN_W   = 160,
    parameter  int SCREEN_H   = 120,
    parameter  int FIFO_DEPTH = 8,
    parameter  int ADDR_W     = 15,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    pixel_sink_if.slave      pix,
    input  logic             clear_stats,
    output logic [LVL_W-1:0] fifo_level,
    output logic [7:0]       clipped_count,
    output logic [7:0]       overflow_count
);
    localparam logic [11:0]      W_LIM    = 12'(SCREEN_W);
    localparam logic [11:0]      H_LIM    = 12'(SCREEN_H);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic              stg_vld;
    logic [ADDR_W-1:0] stg_addr;
    logic [2:0]        stg_col;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [2:0]        col_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;

    logic in_range, clip, pop, push, drop;

    assign in_range = ({1'b0, pix.x_in} < W_LIM) && ({1'b0, pix.y_in} < H_LIM);
    assign clip     = pix.writeEn && !in_range;
    assign pop      = pix.mem_we && pix.mem_ready;
    // a full FIFO still accepts when the head leaves on the same edge
    assign push     = stg_vld && ((level != FULL_LVL) || pop);
    assign drop     = stg_vld && !push;

    assign pix.mem_we   = (level != '0);
    assign pix.mem_addr = addr_mem[rd_ptr];
    assign pix.mem_data = col_mem[rd_ptr];
    assign fifo_level   = level;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_vld  <= 1'b0;
            stg_addr <= '0;
            stg_col  <= '0;
        end else begin
            stg_vld <= pix.writeEn && in_range;
            if (pix.writeEn && in_range) begin
                stg_addr <= ADDR_W'(32'(pix.y_in) * 32'(SCREEN_W) + 32'(pix.x_in));
                stg_col  <= pix.colour_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                col_mem[i]  <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= stg_addr;
                col_mem[wr_ptr]  <= stg_col;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // clear wins over a coincident increment; both counters stick at 255
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clipped_count  <= '0;
            overflow_count <= '0;
        end else if (clear_stats) begin
            clipped_count  <= '0;
            overflow_count <= '0;
        end else begin
            if (clip && clipped_count != 8'hFF)
                clipped_count <= clipped_count + 8'd1;
            if (drop && overflow_count != 8'hFF)
                overflow_count <= overflow_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_pixel_sink.sv
// Bench for pixel_sink: directed table, hand sequences for overflow/reset/
// saturation, then random traffic against a queue-based reference model.
module tb_pixel_sink;
    localparam int SW = 160;
    localparam int SH = 120;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_stats = 1'b0;
    logic [3:0] fifo_level;
    logic [7:0] clipped_count, overflow_count;

    pixel_sink_if #(.ADDR_W(15)) pif ();

    pixel_sink #(.SCREEN_W(SW), .SCREEN_H(SH), .FIFO_DEPTH(DEPTH), .ADDR_W(15)) dut (
        .clock(clock), .reset_n(reset_n), .pix(pif.slave), .clear_stats(clear_stats),
        .fifo_level(fifo_level), .clipped_count(clipped_count),
        .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int col; } pix_t;
    typedef struct {
        int x, y, c, we, rdy;
        int e_we, e_addr, e_data, e_lvl, e_clip;
    } vec_t;

    pix_t q[$];
    bit   stg_v;
    pix_t stg;
    int   clip_m, ovf_m;
    int   n_total, n_pass;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic model_reset();
        q.delete();
        stg_v  = 1'b0;
        clip_m = 0;
        ovf_m  = 0;
    endtask

    // One clock: drive at negedge, advance the model, compare at next negedge.
    task automatic cyc(input int x, input int y, input int c,
                       input bit we, input bit rdy, input bit clr);
        bit in_rng, dropped;
        pif.x_in      = 11'(x);
        pif.y_in      = 11'(y);
        pif.colour_in = 3'(c);
        pif.writeEn   = we;
        pif.mem_ready = rdy;
        clear_stats   = clr;
        in_rng  = (x < SW) && (y < SH);
        dropped = 1'b0;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (stg_v) begin
            if (q.size() < DEPTH) q.push_back(stg);
            else dropped = 1'b1;
        end
        if (clr) begin
            clip_m = 0;
            ovf_m  = 0;
        end else begin
            if (we && !in_rng) clip_m = sat(clip_m);
            if (dropped) ovf_m = sat(ovf_m);
        end
        stg_v = we && in_rng;
        if (stg_v) stg = '{addr: (y * SW + x) % 32768, col: c};
        @(posedge clock);
        @(negedge clock);
        chk("mem_we", int'(pif.mem_we), int'(q.size() > 0));
        chk("fifo_level", int'(fifo_level), q.size());
        chk("clipped_count", int'(clipped_count), clip_m);
        chk("overflow_count", int'(overflow_count), ovf_m);
        if (q.size() > 0) begin
            chk("mem_addr", int'(pif.mem_addr), q[0].addr);
            chk("mem_data", int'(pif.mem_data), q[0].col);
        end
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 0, 1'b0, rdy, 1'b0);
    endtask

    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cyc(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].we[0], tbl[i].rdy[0], 1'b0);
            chk("tbl_we", int'(pif.mem_we), tbl[i].e_we);
            chk("tbl_level", int'(fifo_level), tbl[i].e_lvl);
            chk("tbl_clip", int'(clipped_count), tbl[i].e_clip);
            if (tbl[i].e_we != 0) begin
                chk("tbl_addr", int'(pif.mem_addr), tbl[i].e_addr);
                chk("tbl_data", int'(pif.mem_data), tbl[i].e_data);
            end
        end
    endtask

    initial begin
        int saved_ovf;
        n_total = 0;
        n_pass  = 0;
        model_reset();
        pif.x_in = '0; pif.y_in = '0; pif.colour_in = '0;
        pif.writeEn = 1'b0; pif.mem_ready = 1'b0;

        //           x    y    c  we rdy  we  addr   d lvl clip
        tbl[0] = '{ 20,  80,  5, 1, 1,   0,     0, 0, 0, 0};
        tbl[1] = '{  0,   0,  0, 0, 1,   1, 12820, 5, 1, 0};
        tbl[2] = '{  0,   0,  0, 0, 1,   0,     0, 0, 0, 0};
        tbl[3] = '{160,   5,  1, 1, 1,   0,     0, 0, 0, 1};
        tbl[4] = '{  3, 120,  2, 1, 1,   0,     0, 0, 0, 2};
        tbl[5] = '{159, 119,  3, 1, 1,   0,     0, 0, 0, 2};
        tbl[6] = '{  0,   0,  0, 0, 1,   1, 19199, 3, 1, 2};
        tbl[7] = '{  0,   0,  0, 0, 1,   0,     0, 0, 0, 2};

        @(negedge clock);
        chk("rst_we", int'(pif.mem_we), 0);
        chk("rst_addr", int'(pif.mem_addr), 0);
        chk("rst_data", int'(pif.mem_data), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_clip", int'(clipped_count), 0);
        chk("rst_ovf", int'(overflow_count), 0);
        @(negedge clock);
        reset_n = 1'b1;

        run_table(0, 7);

        // overflow: 21 writes with memory stalled
        for (int i = 0; i <= 20; i++) cyc(i, 0, i % 8, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("ovf_level", int'(fifo_level), 8);
        chk("ovf_count", int'(overflow_count), 13);
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", int'(pif.mem_addr), i);
            idle(1'b1);
        end
        chk("drain_done_we", int'(pif.mem_we), 0);

        // full FIFO with simultaneous push and pop every cycle
        for (int i = 30; i < 40; i++) cyc(i, 1, 7, 1'b1, 1'b0, 1'b0);
        saved_ovf = int'(overflow_count);
        for (int i = 40; i < 60; i++) begin
            cyc(i, 1, i % 8, 1'b1, 1'b1, 1'b0);
            chk("full_level", int'(fifo_level), 8);
            chk("full_ovf", int'(overflow_count), saved_ovf);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);

        // reset while buffered with ready toggling
        for (int i = 0; i < 5; i++) cyc(i + 100, 2, 4, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("pre_rst_level", int'(fifo_level), 5);
        pif.mem_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_we", int'(pif.mem_we), 0);
        chk("async_level", int'(fifo_level), 0);
        chk("async_ovf", int'(overflow_count), 0);
        chk("async_clip", int'(clipped_count), 0);
        model_reset();
        pif.writeEn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        run_table(0, 2);

        // clipped counter saturation and clear priority
        for (int i = 0; i < 300; i++) cyc(200 + (i % 50), i % 130, 1, 1'b1, 1'b1, 1'b0);
        chk("clip_sat", int'(clipped_count), 255);
        cyc(300, 300, 0, 1'b1, 1'b1, 1'b1);
        chk("clip_clear", int'(clipped_count), 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int x, y;
            x = ($urandom_range(0, 15) == 0) ? 2047 : int'($urandom_range(0, 175));
            y = int'($urandom_range(0, 132));
            cyc(x, y, int'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 60) == 0));
        end
        for (int i = 0; i < 12; i++) idle(1'b1);
        chk("final_level", int'(fifo_level), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pixel_sink.md
Name: pixel_sink

Overview:
- Receiving end of the pixel-write interface that drawing blocks (paddle, puck, field) drive: x, y, colour, writeEn.
- Clips off-screen pixels, converts in-range (x,y) to a linear framebuffer address, and buffers writes in a small FIFO.
- Drains the FIFO into the video-memory write port under a valid/ready handshake.
- Sits between the drawing blocks and the framebuffer RAM.
- Drawers have no backpressure, so overflow is dropped and counted.

Parameters:
SCREEN_W, 160, visible width in pixels; x valid range 0..SCREEN_W-1
SCREEN_H, 120, visible height in pixels; y valid range 0..SCREEN_H-1
FIFO_DEPTH, 8, buffered pixel writes; power of two, at least 2
ADDR_W, 15, framebuffer address width; must hold SCREEN_W*SCREEN_H-1

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
x_in  in  11  pixel x from drawer
y_in  in  11  pixel y from drawer
colour_in  in  3  pixel colour from drawer
writeEn  in  1  pixel write strobe, sampled every rising edge
mem_addr  out  ADDR_W  framebuffer address of FIFO head
mem_data  out  3  colour of FIFO head
mem_we  out  1  head valid (FIFO non-empty)
mem_ready  in  1  framebuffer accepts head this cycle
clear_stats  in  1  synchronous clear of both counters
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
clipped_count  out  8  saturating count of off-screen writes
overflow_count  out  8  saturating count of writes dropped on full FIFO

Behaviour:
- Reset (async, reset_n=0): stage valid=0, FIFO empty, mem_we=0, mem_addr=0, mem_data=0, fifo_level=0, both counters 0.
- Reset mid-drain discards all buffered pixels.
- Stage 0 (sample): on each edge with writeEn=1, x_in and y_in are compared unsigned.
- If x_in>=SCREEN_W or y_in>=SCREEN_H, the pixel is clipped: it is not staged and clipped_count increments.
- Otherwise the stage register loads addr=y_in*SCREEN_W+x_in, truncated to ADDR_W, plus colour_in, and stage valid=1.
- With writeEn=0, stage valid=0 next cycle.
- Stage 1 (push): a valid stage entry pushes into the FIFO on the next edge.
- Push succeeds if the FIFO is not full, or if it is full and a pop occurs the same edge. Simultaneous push+pop at full leaves the level unchanged.
- Otherwise the pixel is dropped and overflow_count increments.
- The stage never stalls; it is overwritten every cycle.
- Drain: mem_we=1 whenever fifo_level>0. mem_addr and mem_data present the head entry, registered from FIFO storage and stable while mem_we=1 and mem_ready=0.
- Pop occurs on an edge with mem_we=1 and mem_ready=1.
- mem_ready is ignored when empty.
- Simultaneous push+pop when empty is not possible; the head becomes visible one cycle after push.
- Latency: an in-range write sampled at edge N reaches the FIFO at edge N+1. mem_we is high after edge N+1, i.e. during cycle N+2, when the FIFO was empty.
- With mem_ready=1 throughout, throughput is one pixel per cycle.
- Ordering: strict FIFO; write order to memory equals accepted sample order.
- Counters: each increments by at most 1 per cycle and saturates at 255.
- clear_stats=1 zeroes both counters at the edge, and takes priority over a coincident increment.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level is the exact occupancy, 0..FIFO_DEPTH.
- Repeated identical pixels are not merged; each is written.

Test Plan:
- Reset, then writeEn for one cycle with x=20, y=80, colour=101, mem_ready=1 -> mem_we high exactly one cycle, two cycles after sample; mem_addr=12820, mem_data=101; fifo_level returns to 0.
- x=160,y=5 then x=3,y=120, writeEn=1 -> no mem_we; clipped_count=2. Then x=159,y=119 -> mem_addr=19199.
- mem_ready=0, 21 consecutive in-range writes x=0..20, y=0 -> fifo_level=8, overflow_count=13. Then mem_ready=1 -> 8 writes in order, addr 0..7, one per cycle, then mem_we=0.
- FIFO full, mem_ready=1, continuous writes -> fifo_level stays 8, overflow_count unchanged, all pixels appear in order.
- 300 clipped writes -> clipped_count=255. clear_stats coincident with another clip -> 0 next cycle.
- FIFO at level 5 with mem_ready toggling, reset_n pulsed low mid-cycle -> mem_we=0 immediately (asynchronously), fifo_level=0, counters 0. The next write after release behaves as in scenario 1.
